mem_access_ctrl: RTL

Upstream MAR/MDR sequencer between the LC-3b datapath/microsequencer and the memory stage. It accepts one load/store request at a time and latches address into MAR and store data into MDR. It drives the memory enable/write/byte-lane signals and waits on the memory ready. It returns load data, aligned and sign-extended for byte loads, with a one-cycle done pulse.

---
 rtl/mem_access_ctrl_pkg.sv | 23 ++
 rtl/mem_access_ctrl_if.sv | 33 +++
 rtl/mem_access_ctrl_byte_align.sv | 40 ++++
 rtl/mem_access_ctrl.sv | 156 +++++++++++++++
 4 files changed

// File: rtl/mem_access_ctrl_pkg.sv
// Shared types and constants for the LC-3b MAR/MDR memory access sequencer.
// Includes the byte-load sign extension helper used by mem_byte_align.
package mem_access_ctrl_pkg;

    localparam int ADDR_W_DEF         = 16;
    localparam int DATA_W_DEF         = 16;
    localparam int TIMEOUT_CYCLES_DEF = 255;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        DONE   = 2'd2
    } state_t;

    localparam logic [1:0] BE_WORD = 2'b11;
    localparam logic [1:0] BE_LO   = 2'b01;
    localparam logic [1:0] BE_HI   = 2'b10;

    function automatic logic [15:0] sign_extend(input logic [7:0] b);
        return {{8{b[7]}}, b};
    endfunction

endpackage

// File: rtl/mem_access_ctrl_if.sv
// Request/response and memory-side bus of mem_access_ctrl.
// slave = the sequencer itself, master = datapath plus memory driving it.
interface mem_access_ctrl_if;
    import mem_access_ctrl_pkg::*;

    logic                  req_start;
    logic                  req_we;
    logic                  req_byte;
    logic [ADDR_W_DEF-1:0] req_addr;
    logic [DATA_W_DEF-1:0] req_wdata;
    logic                  busy;
    logic                  done;
    logic                  err;
    logic [DATA_W_DEF-1:0] rdata;
    logic                  mem_en;
    logic                  mem_we;
    logic [ADDR_W_DEF-1:0] mem_addr;
    logic [DATA_W_DEF-1:0] mem_wdata;
    logic [1:0]            mem_be;
    logic                  mem_r;
    logic [DATA_W_DEF-1:0] mem_rdata;

    modport slave (
        input  req_start, req_we, req_byte, req_addr, req_wdata, mem_r, mem_rdata,
        output busy, done, err, rdata, mem_en, mem_we, mem_addr, mem_wdata, mem_be
    );

    modport master (
        output req_start, req_we, req_byte, req_addr, req_wdata, mem_r, mem_rdata,
        input  busy, done, err, rdata, mem_en, mem_we, mem_addr, mem_wdata, mem_be
    );

endinterface

// File: rtl/mem_access_ctrl_byte_align.sv
// mem_byte_align: byte-lane handling, combinational only.
// Store side builds lane enables and replicated data; load side picks and sign-extends.
module mem_byte_align
    import mem_access_ctrl_pkg::*;
(
    input  logic        st_byte,
    input  logic        st_lsb,
    input  logic [15:0] st_wdata,
    output logic [1:0]  st_be,
    output logic [15:0] st_word,
    input  logic        ld_byte,
    input  logic        ld_lsb,
    input  logic [15:0] ld_rdata,
    output logic [15:0] ld_word
);

    // Store lane select and byte replication onto both halves of the bus.
    always_comb begin
        st_be   = BE_WORD;
        st_word = st_wdata;
        if (st_byte) begin
            st_be   = st_lsb ? BE_HI : BE_LO;
            st_word = {st_wdata[7:0], st_wdata[7:0]};
        end else begin
            st_be   = BE_WORD;
            st_word = st_wdata;
        end
    end

    // Load byte select and sign extension.
    always_comb begin
        ld_word = ld_rdata;
        if (ld_byte) begin
            ld_word = sign_extend(ld_lsb ? ld_rdata[15:8] : ld_rdata[7:0]);
        end else begin
            ld_word = ld_rdata;
        end
    end

endmodule

// File: rtl/mem_access_ctrl.sv
// mem_access_ctrl: one-at-a-time load/store sequencer latching MAR/MDR and driving memory.
// Optional access watchdog enabled by defining MEM_CTRL_TIMEOUT_EN.
module mem_access_ctrl
    import mem_access_ctrl_pkg::*;
#(
    parameter int ADDR_W         = ADDR_W_DEF,
    parameter int DATA_W         = DATA_W_DEF,
    parameter int TIMEOUT_CYCLES = TIMEOUT_CYCLES_DEF
) (
    input logic               clk_50,
    input logic               rst,
    mem_access_ctrl_if.slave  bus
);

    if (ADDR_W != 16 || DATA_W != 16 || TIMEOUT_CYCLES < 1 || TIMEOUT_CYCLES > 255) begin : g_bad_cfg
        $error("mem_access_ctrl: unsupported parameter set");
    end

    state_t      state_r, state_nxt_s;
    logic        accept_s, capture_s, err_nxt_s, tmo_hit_s;
    logic [15:0] mar_r, mdr_r, rdata_r;
    logic        we_r, byte_r;
    logic        busy_r, done_r, err_r, mem_en_r;
    logic [1:0]  mem_be_r;
    logic [1:0]  st_be_s;
    logic [15:0] st_word_s, ld_word_s;

    mem_byte_align u_align (
        .st_byte  (bus.req_byte),
        .st_lsb   (bus.req_addr[0]),
        .st_wdata (bus.req_wdata),
        .st_be    (st_be_s),
        .st_word  (st_word_s),
        .ld_byte  (byte_r),
        .ld_lsb   (mar_r[0]),
        .ld_rdata (bus.mem_rdata),
        .ld_word  (ld_word_s)
    );

`ifdef MEM_CTRL_TIMEOUT_EN
    logic [7:0] tmo_cnt_r;

    // Watchdog: counts ACCESS cycles that ended without mem_r.
    always_ff @(posedge clk_50) begin
        if (rst) begin
            tmo_cnt_r <= 8'd0;
        end else if (accept_s) begin
            tmo_cnt_r <= 8'd0;
        end else if (state_r == ACCESS && !bus.mem_r) begin
            tmo_cnt_r <= tmo_cnt_r + 8'd1;
        end else begin
            tmo_cnt_r <= tmo_cnt_r;
        end
    end

    assign tmo_hit_s = (tmo_cnt_r == 8'(TIMEOUT_CYCLES - 1));
`else
    assign tmo_hit_s = 1'b0;
`endif

    // State register.
    always_ff @(posedge clk_50) begin
        if (rst) begin
            state_r <= IDLE;
        end else begin
            state_r <= state_nxt_s;
        end
    end

    // Next-state decode; misaligned word requests skip ACCESS and report err.
    always_comb begin
        state_nxt_s = state_r;
        accept_s    = 1'b0;
        capture_s   = 1'b0;
        err_nxt_s   = 1'b0;
        case (state_r)
            IDLE: begin
                if (bus.req_start) begin
                    accept_s = 1'b1;
                    if (!bus.req_byte && bus.req_addr[0]) begin
                        state_nxt_s = DONE;
                        err_nxt_s   = 1'b1;
                    end else begin
                        state_nxt_s = ACCESS;
                    end
                end else begin
                    state_nxt_s = IDLE;
                end
            end
            ACCESS: begin
                if (bus.mem_r) begin
                    state_nxt_s = DONE;
                    capture_s   = 1'b1;
                end else if (tmo_hit_s) begin
                    state_nxt_s = DONE;
                    err_nxt_s   = 1'b1;
                end else begin
                    state_nxt_s = ACCESS;
                end
            end
            DONE:    state_nxt_s = IDLE;
            default: state_nxt_s = IDLE;
        endcase
    end

    // MAR/MDR latch and registered status/memory outputs, all keyed off next state.
    always_ff @(posedge clk_50) begin
        if (rst) begin
            mar_r    <= 16'h0000;
            mdr_r    <= 16'h0000;
            we_r     <= 1'b0;
            byte_r   <= 1'b0;
            mem_be_r <= 2'b00;
            rdata_r  <= 16'h0000;
            busy_r   <= 1'b0;
            done_r   <= 1'b0;
            err_r    <= 1'b0;
            mem_en_r <= 1'b0;
        end else begin
            busy_r   <= (state_nxt_s != IDLE);
            done_r   <= (state_nxt_s == DONE);
            err_r    <= err_nxt_s;
            mem_en_r <= (state_nxt_s == ACCESS);
            if (accept_s) begin
                mar_r    <= bus.req_addr;
                mdr_r    <= st_word_s;
                we_r     <= bus.req_we;
                byte_r   <= bus.req_byte;
                mem_be_r <= st_be_s;
            end else begin
                mar_r    <= mar_r;
                mdr_r    <= mdr_r;
                we_r     <= we_r;
                byte_r   <= byte_r;
                mem_be_r <= mem_be_r;
            end
            if (capture_s && !we_r) begin
                rdata_r <= ld_word_s;
            end else begin
                rdata_r <= rdata_r;
            end
        end
    end

    // MDR already holds lane-replicated store data.
    assign bus.busy      = busy_r;
    assign bus.done      = done_r;
    assign bus.err       = err_r;
    assign bus.rdata     = rdata_r;
    assign bus.mem_en    = mem_en_r;
    assign bus.mem_we    = we_r;
    assign bus.mem_addr  = {mar_r[15:1], 1'b0};
    assign bus.mem_wdata = mdr_r;
    assign bus.mem_be    = mem_be_r;

endmodule
